// File: rtl/ysyx_040750_ex_mem_reg.sv
// ysyx_040750_ex_mem_reg: EX/MEM pipeline register built as a 2-entry skid buffer with registered ready.
// Optional build macro YSYX_040750_EX_MEM_PERF_EN adds stall/flush event counters.
`default_nettype none

module ysyx_040750_ex_mem_reg #(
    parameter int DW  = 64,
    parameter int PCW = 64
) (
    input  logic           I_sys_clk,
    input  logic           I_rst,
    input  logic           I_result_valid,
    input  logic [DW-1:0]  I_result,
    input  logic [DW-1:0]  I_csr_data,
    input  logic [DW-1:0]  I_store_data,
    input  logic [PCW-1:0] I_pc,
    input  logic [4:0]     I_rd,
    input  logic           I_rd_wen,
    input  logic           I_csr_wen,
    input  logic           I_mem_ren,
    input  logic           I_mem_wen,
    input  logic [2:0]     I_mem_size,
    input  logic           I_flush,
    input  logic           I_MEM_ready,
    output logic           O_EX_MEM_ready,
    output logic           O_valid,
    output logic [DW-1:0]  O_result,
    output logic [DW-1:0]  O_csr_data,
    output logic [DW-1:0]  O_store_data,
    output logic [PCW-1:0] O_pc,
    output logic [4:0]     O_rd,
    output logic           O_rd_wen,
    output logic           O_csr_wen,
    output logic           O_mem_ren,
    output logic           O_mem_wen,
`ifdef YSYX_040750_EX_MEM_PERF_EN
    output logic [31:0]    O_stall_cnt,
    output logic [31:0]    O_flush_cnt,
`endif
    output logic [2:0]     O_mem_size
);

    typedef struct packed {
        logic [DW-1:0]  result;
        logic [DW-1:0]  csr_data;
        logic [DW-1:0]  store_data;
        logic [PCW-1:0] pc;
        logic [4:0]     rd;
        logic           rd_wen;
        logic           csr_wen;
        logic           mem_ren;
        logic           mem_wen;
        logic [2:0]     mem_size;
    } payload_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_t;

    state_t   r_state, w_state_nxt;
    payload_t r_main, r_skid, w_main_nxt, w_skid_nxt, w_in;
    logic     r_ready;
    logic     w_in_fire, w_out_fire, w_valid;

    assign w_in = '{result: I_result, csr_data: I_csr_data, store_data: I_store_data,
                    pc: I_pc, rd: I_rd, rd_wen: I_rd_wen, csr_wen: I_csr_wen,
                    mem_ren: I_mem_ren, mem_wen: I_mem_wen, mem_size: I_mem_size};

    assign w_valid    = (r_state != ST_EMPTY);
    assign w_in_fire  = I_result_valid && r_ready;
    assign w_out_fire = w_valid && I_MEM_ready;

    // Main is always the FIFO head; skid only ever holds the younger entry.
    always_comb begin
        w_state_nxt = r_state;
        w_main_nxt  = r_main;
        w_skid_nxt  = r_skid;
        if (I_flush) begin
            w_state_nxt = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_in_fire) begin
                        w_main_nxt  = w_in;
                        w_state_nxt = ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (w_in_fire && w_out_fire) begin
                        w_main_nxt = w_in;
                    end else if (w_in_fire) begin
                        w_skid_nxt  = w_in;
                        w_state_nxt = ST_SKID;
                    end else if (w_out_fire) begin
                        w_state_nxt = ST_EMPTY;
                    end
                end
                ST_SKID: begin
                    if (w_out_fire) begin
                        w_main_nxt  = r_skid;
                        w_state_nxt = ST_FULL;
                    end
                end
                default: w_state_nxt = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge I_sys_clk or posedge I_rst) begin
        if (I_rst) begin
            r_state <= ST_EMPTY;
            r_ready <= 1'b1;
            r_main  <= '0;
            r_skid  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ready <= (w_state_nxt != ST_SKID);
            r_main  <= w_main_nxt;
            r_skid  <= w_skid_nxt;
        end
    end

    assign O_EX_MEM_ready = r_ready;
    assign O_valid        = w_valid;
    assign O_result       = r_main.result;
    assign O_csr_data     = r_main.csr_data;
    assign O_store_data   = r_main.store_data;
    assign O_pc           = r_main.pc;
    assign O_rd           = r_main.rd;
    assign O_mem_size     = r_main.mem_size;
    // Side-effect enables must never leak out of an invalid slot.
    assign O_rd_wen       = r_main.rd_wen  && w_valid;
    assign O_csr_wen      = r_main.csr_wen && w_valid;
    assign O_mem_ren      = r_main.mem_ren && w_valid;
    assign O_mem_wen      = r_main.mem_wen && w_valid;

`ifdef YSYX_040750_EX_MEM_PERF_EN
    logic [31:0] r_stall_cnt, r_flush_cnt;

    always_ff @(posedge I_sys_clk or posedge I_rst) begin
        if (I_rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_valid && !I_MEM_ready) r_stall_cnt <= r_stall_cnt + 32'd1;
            if (I_flush && w_valid)      r_flush_cnt <= r_flush_cnt + 32'd1;
        end
    end

    assign O_stall_cnt = r_stall_cnt;
    assign O_flush_cnt = r_flush_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ysyx_040750_ex_mem_reg.sv
// tb_ysyx_040750_ex_mem_reg: directed self-checking bench for the EX/MEM skid-buffer register.
`default_nettype none

module tb_ysyx_040750_ex_mem_reg;

    logic        clk, rst;
    logic        i_result_valid, i_rd_wen, i_csr_wen, i_mem_ren, i_mem_wen, i_flush, i_mem_ready;
    logic [63:0] i_result, i_csr_data, i_store_data, i_pc;
    logic [4:0]  i_rd;
    logic [2:0]  i_mem_size;
    logic        o_ready, o_valid, o_rd_wen, o_csr_wen, o_mem_ren, o_mem_wen;
    logic [63:0] o_result, o_csr_data, o_store_data, o_pc;
    logic [4:0]  o_rd;
    logic [2:0]  o_mem_size;
`ifdef YSYX_040750_EX_MEM_PERF_EN
    logic [31:0] o_stall_cnt, o_flush_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;

    ysyx_040750_ex_mem_reg #(.DW(64), .PCW(64)) dut (
        .I_sys_clk(clk), .I_rst(rst),
        .I_result_valid(i_result_valid), .I_result(i_result), .I_csr_data(i_csr_data),
        .I_store_data(i_store_data), .I_pc(i_pc), .I_rd(i_rd), .I_rd_wen(i_rd_wen),
        .I_csr_wen(i_csr_wen), .I_mem_ren(i_mem_ren), .I_mem_wen(i_mem_wen),
        .I_mem_size(i_mem_size), .I_flush(i_flush), .I_MEM_ready(i_mem_ready),
        .O_EX_MEM_ready(o_ready), .O_valid(o_valid), .O_result(o_result),
        .O_csr_data(o_csr_data), .O_store_data(o_store_data), .O_pc(o_pc), .O_rd(o_rd),
        .O_rd_wen(o_rd_wen), .O_csr_wen(o_csr_wen), .O_mem_ren(o_mem_ren),
        .O_mem_wen(o_mem_wen),
`ifdef YSYX_040750_EX_MEM_PERF_EN
        .O_stall_cnt(o_stall_cnt), .O_flush_cnt(o_flush_cnt),
`endif
        .O_mem_size(o_mem_size)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_result_valid = 0; i_result = '0; i_csr_data = '0; i_store_data = '0; i_pc = '0;
        i_rd = '0; i_rd_wen = 0; i_csr_wen = 0; i_mem_ren = 0; i_mem_wen = 0;
        i_mem_size = '0; i_flush = 0;
    endtask

    task automatic push(input logic [63:0] v);
        i_result_valid = 1; i_result = v; i_rd = v[4:0]; i_rd_wen = 1;
        i_pc = 64'h8000_0000 + v; i_mem_size = v[2:0];
    endtask

    task automatic do_reset();
        idle_inputs(); i_mem_ready = 1; rst = 1;
        tick(); tick();
        rst = 0;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got %b want 0", o_valid); end
        n_cmp++; if (o_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready got %b want 1", o_ready); end
        n_cmp++; if (o_result !== 64'h0) begin n_err++; $display("FAIL rst_result got %h want 0", o_result); end
        n_cmp++; if (o_pc !== 64'h0) begin n_err++; $display("FAIL rst_pc got %h want 0", o_pc); end
        i_result_valid = 1; i_result = 64'h1234; i_rd = 5'd5; i_rd_wen = 1; i_csr_wen = 1;
        i_csr_data = 64'hC5; i_mem_size = 3'b101; i_mem_ready = 0;
        tick();
        idle_inputs();
        n_cmp++; if (o_valid !== 1'b1) begin n_err++; $display("FAIL push_valid got %b want 1", o_valid); end
        n_cmp++; if (o_result !== 64'h1234) begin n_err++; $display("FAIL push_result got %h want 1234", o_result); end
        n_cmp++; if (o_rd !== 5'd5) begin n_err++; $display("FAIL push_rd got %0d want 5", o_rd); end
        n_cmp++; if (o_rd_wen !== 1'b1 || o_csr_wen !== 1'b1) begin n_err++; $display("FAIL push_wen got %b%b want 11", o_rd_wen, o_csr_wen); end
        n_cmp++; if (o_csr_data !== 64'hC5 || o_mem_size !== 3'b101) begin n_err++; $display("FAIL push_fields got %h/%b want c5/101", o_csr_data, o_mem_size); end
        #2 rst = 1;
        #1;
        n_cmp++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL async_rst_valid got %b want 0", o_valid); end
        n_cmp++; if (o_ready !== 1'b1) begin n_err++; $display("FAIL async_rst_ready got %b want 1", o_ready); end
        n_cmp++; if (o_rd_wen !== 1'b0) begin n_err++; $display("FAIL async_rst_rd_wen got %b want 0", o_rd_wen); end
        n_cmp++; if (o_result !== 64'h0) begin n_err++; $display("FAIL async_rst_result got %h want 0", o_result); end
        tick();
        rst = 0; i_mem_ready = 1;
        tick();
    endtask

    task automatic test_streaming();
        i_mem_ready = 1;
        for (int i = 1; i <= 8; i++) begin
            push(64'(i));
            tick();
            n_cmp++; if (o_valid !== 1'b1 || o_result !== 64'(i)) begin n_err++; $display("FAIL stream_%0d got v=%b r=%h want v=1 r=%h", i, o_valid, o_result, 64'(i)); end
            n_cmp++; if (o_ready !== 1'b1) begin n_err++; $display("FAIL stream_ready_%0d got %b want 1", i, o_ready); end
            n_cmp++; if (o_pc !== 64'h8000_0000 + 64'(i)) begin n_err++; $display("FAIL stream_pc_%0d got %h want %h", i, o_pc, 64'h8000_0000 + 64'(i)); end
        end
        idle_inputs();
        tick();
        n_cmp++; if (o_valid !== 1'b0 || o_rd_wen !== 1'b0) begin n_err++; $display("FAIL stream_drain got v=%b wen=%b want 0/0", o_valid, o_rd_wen); end
    endtask

    task automatic test_backpressure();
        i_mem_ready = 0;
        push(64'hA);
        tick();
        n_cmp++; if (o_ready !== 1'b1 || o_result !== 64'hA) begin n_err++; $display("FAIL bp_a got rdy=%b r=%h want 1/a", o_ready, o_result); end
        push(64'hB);
        tick();
        idle_inputs();
        n_cmp++; if (o_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready_low got %b want 0", o_ready); end
        n_cmp++; if (o_result !== 64'hA || o_valid !== 1'b1) begin n_err++; $display("FAIL bp_hold got v=%b r=%h want 1/a", o_valid, o_result); end
        tick();
        n_cmp++; if (o_result !== 64'hA || o_ready !== 1'b0) begin n_err++; $display("FAIL bp_hold2 got rdy=%b r=%h want 0/a", o_ready, o_result); end
        i_mem_ready = 1;
        tick();
        n_cmp++; if (o_result !== 64'hB || o_valid !== 1'b1) begin n_err++; $display("FAIL bp_b got v=%b r=%h want 1/b", o_valid, o_result); end
        n_cmp++; if (o_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready_back got %b want 1", o_ready); end
        tick();
        n_cmp++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL bp_empty got %b want 0", o_valid); end
    endtask

    task automatic test_flush();
        i_mem_ready = 0;
        push(64'hA); tick();
        push(64'hB); tick();
        push(64'hC); i_flush = 1;
        tick();
        idle_inputs();
        n_cmp++; if (o_valid !== 1'b0 || o_ready !== 1'b1) begin n_err++; $display("FAIL flush_skid got v=%b rdy=%b want 0/1", o_valid, o_ready); end
        n_cmp++; if (o_rd_wen !== 1'b0) begin n_err++; $display("FAIL flush_wen got %b want 0", o_rd_wen); end
        push(64'hA); tick();
        push(64'hC); i_flush = 1;
        tick();
        idle_inputs(); i_mem_ready = 1;
        n_cmp++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL flush_drop_c got v=%b r=%h want v=0", o_valid, o_result); end
        for (int k = 0; k < 3; k++) begin
            tick();
            n_cmp++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL flush_ghost_%0d got v=%b r=%h want v=0", k, o_valid, o_result); end
        end
    endtask

    task automatic test_multicycle();
        logic [63:0] seen[$];
        for (int c = 0; c < 80; c++) begin
            idle_inputs();
            if (c == 0)  push(64'd7);
            if (c == 34) push(64'd9);
            i_mem_ready = (c >= 68) ? 1'b1 : 1'($urandom_range(0, 1));
            if (o_valid && i_mem_ready) seen.push_back(o_result);
            tick();
        end
        idle_inputs();
        n_cmp++; if (seen.size() !== 2) begin n_err++; $display("FAIL multi_count got %0d want 2", seen.size()); end
        if (seen.size() == 2) begin
            n_cmp++; if (seen[0] !== 64'd7 || seen[1] !== 64'd9) begin n_err++; $display("FAIL multi_order got %0d,%0d want 7,9", seen[0], seen[1]); end
        end
    endtask

`ifdef YSYX_040750_EX_MEM_PERF_EN
    task automatic test_perf();
        do_reset();
        i_mem_ready = 0;
        push(64'h55); tick();
        idle_inputs();
        for (int k = 0; k < 5; k++) tick();
        i_mem_ready = 1; i_flush = 1;
        tick();
        idle_inputs();
        n_cmp++; if (o_stall_cnt !== 32'd5) begin n_err++; $display("FAIL perf_stall got %0d want 5", o_stall_cnt); end
        n_cmp++; if (o_flush_cnt !== 32'd1) begin n_err++; $display("FAIL perf_flush got %0d want 1", o_flush_cnt); end
    endtask
`endif

    initial begin
        rst = 1; i_mem_ready = 1;
        idle_inputs();
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush();
        test_multicycle();
`ifdef YSYX_040750_EX_MEM_PERF_EN
        test_perf();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
